// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table extractor.
// Optional 3-sample voting is enabled with TT_VOTE_EN.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_e;

    localparam int TMR_W = 8;

    function automatic int code_w(input int num_inputs);
        return 1 << num_inputs;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter for the per-row settle hold.
// Flags: zero when empty, expire when the next decrement empties it.
module tt_settle_timer
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero,
    output logic             expire
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    assign zero   = (count_q == '0);
    assign expire = (count_q == TMR_W'(1));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && !zero) begin
            count_d = count_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all input rows of an external gate and packs its response into a code.
// Row 0 lands in the code MSB. TT_VOTE_EN adds 2-of-3 voting and a glitch flag.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int NUM_INPUTS    = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [NUM_INPUTS-1:0]         stim,
    input  logic                          resp,
    output logic                          busy,
    output logic                          done,
    output logic [code_w(NUM_INPUTS)-1:0] code
`ifdef TT_VOTE_EN
    ,
    output logic                          glitch
`endif
);

    localparam int CODE_W = code_w(NUM_INPUTS);
    localparam int ROW_W  = NUM_INPUTS + 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CODE_W - 1);
    localparam logic [TMR_W-1:0] RELOAD   = TMR_W'(SETTLE_CYCLES);
    localparam tt_state_e        ENTRY    = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    tt_state_e         state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic                  tmr_load;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic                  tmr_expire;
    logic                  row_bit;
    logic                  row_ready;
    logic [NUM_INPUTS-1:0] bit_idx;

`ifdef TT_VOTE_EN
    logic [1:0] vcnt_q, vcnt_d;
    logic [1:0] smp_q, smp_d;
    logic       gacc_q, gacc_d;
    logic       glitch_q, glitch_d;
`endif

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (RELOAD),
        .zero     (tmr_zero),
        .expire   (tmr_expire)
    );

    assign busy = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done = (state_q == DONE);
    assign stim = busy ? row_q[NUM_INPUTS-1:0] : '0;
    assign code = code_q;
    assign bit_idx = ~row_q[NUM_INPUTS-1:0];

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        shadow_d  = shadow_q;
        code_d    = code_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        row_bit   = resp;
        row_ready = 1'b0;
`ifdef TT_VOTE_EN
        vcnt_d   = vcnt_q;
        smp_d    = smp_q;
        gacc_d   = gacc_q;
        glitch_d = glitch_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ENTRY;
                    row_d    = '0;
                    shadow_d = '0;
                    tmr_load = 1'b1;
`ifdef TT_VOTE_EN
                    vcnt_d   = 2'd0;
                    gacc_d   = 1'b0;
                    glitch_d = 1'b0;
`endif
                end
            end
            SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_expire || tmr_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef TT_VOTE_EN
                // Last three cycles of the row feed a majority vote.
                if (vcnt_q != 2'd2) begin
                    smp_d[vcnt_q[0]] = resp;
                    vcnt_d = vcnt_q + 2'd1;
                end else begin
                    row_bit   = (smp_q[0] & smp_q[1]) | (smp_q[0] & resp)
                              | (smp_q[1] & resp);
                    gacc_d    = gacc_q | (smp_q[0] != smp_q[1])
                              | (smp_q[1] != resp);
                    vcnt_d    = 2'd0;
                    row_ready = 1'b1;
                end
`else
                row_ready = 1'b1;
`endif
                if (row_ready) begin
                    shadow_d[bit_idx] = row_bit;
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                        code_d  = shadow_d;
`ifdef TT_VOTE_EN
                        glitch_d = gacc_d;
`endif
                    end else begin
                        state_d  = ENTRY;
                        row_d    = row_q + ROW_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            shadow_q <= '0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            shadow_q <= shadow_d;
            code_q   <= code_d;
        end
    end

`ifdef TT_VOTE_EN
    assign glitch = glitch_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vcnt_q   <= 2'd0;
            smp_q    <= 2'd0;
            gacc_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            vcnt_q   <= vcnt_d;
            smp_q    <= smp_d;
            gacc_q   <= gacc_d;
            glitch_q <= glitch_d;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor; define TT_VOTE_EN to cover voting.
module tb_truth_table_extractor;

    localparam int S   = 4;
    localparam int CW  = 8;
`ifdef TT_VOTE_EN
    localparam int HOLD  = S + 3;
    localparam int HOLD0 = 3;
`else
    localparam int HOLD  = S + 1;
    localparam int HOLD0 = 1;
`endif
    localparam int N  = CW * HOLD;
    localparam int N0 = CW * HOLD0;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] stim;
    logic       resp;
    logic       busy;
    logic       done;
    logic [7:0] code;

    logic       start0;
    logic [2:0] stim0;
    logic       resp0;
    logic       busy0;
    logic       done0;
    logic [7:0] code0;

`ifdef TT_VOTE_EN
    logic glitch;
    logic glitch0;
`endif

    int         checks;
    int         failures;
    int         mode;
    logic [7:0] model_code;
    logic       flip;
    logic [2:0] ridx;

    truth_table_extractor #(.NUM_INPUTS(3), .SETTLE_CYCLES(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stim  (stim),
        .resp  (resp),
        .busy  (busy),
        .done  (done),
        .code  (code)
`ifdef TT_VOTE_EN
        ,
        .glitch(glitch)
`endif
    );

    truth_table_extractor #(.NUM_INPUTS(3), .SETTLE_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .stim  (stim0),
        .resp  (resp0),
        .busy  (busy0),
        .done  (done0),
        .code  (code0)
`ifdef TT_VOTE_EN
        ,
        .glitch(glitch0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ridx = 3'd7 - stim;
        case (mode)
            1:       resp = 1'b0 ^ flip;
            2:       resp = 1'b1 ^ flip;
            default: resp = model_code[ridx] ^ flip;
        endcase
    end

    assign resp0 = ^stim0;

    task automatic sweep(input string name, input logic [7:0] exp_code,
                         input logic [7:0] prev, input int extra,
                         input int flip_at);
        int busy_err;
        int stim_err;
        int code_err;
        int done_cnt;
        int done_at;
        logic [2:0] es;
        busy_err = 0;
        stim_err = 0;
        code_err = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            start = (c == extra);
            flip  = (c == flip_at);
            @(negedge clk);
            if (busy !== (c <= N)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            es = (c <= N) ? 3'((c - 1) / HOLD) : 3'd0;
            if (stim !== es) stim_err++;
            if (c <= N && code !== prev) code_err++;
            if (c > N && code !== exp_code) code_err++;
        end
        start = 1'b0;
        flip  = 1'b0;
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy: %0d bad cycles, required 0", name, busy_err);
        end
        checks++;
        if (stim_err != 0) begin
            failures++;
            $display("FAIL %s stim: %0d bad cycles, required 0", name, stim_err);
        end
        checks++;
        if (done_cnt != 1 || done_at != N + 1) begin
            failures++;
            $display("FAIL %s done: count=%0d at=%0d, required 1 at %0d",
                     name, done_cnt, done_at, N + 1);
        end
        checks++;
        if (code_err != 0) begin
            failures++;
            $display("FAIL %s code stability: %0d bad cycles, required 0",
                     name, code_err);
        end
        checks++;
        if (code !== exp_code) begin
            failures++;
            $display("FAIL %s code: got %h, required %h", name, code, exp_code);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== 3'd0 || code !== 8'h00) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b stim=%h code=%h, required 0 0 0 00",
                     busy, done, stim, code);
        end
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || code0 !== 8'h00) begin
            failures++;
            $display("FAIL reset0: busy=%b done=%b code=%h, required 0 0 00",
                     busy0, done0, code0);
        end
`ifdef TT_VOTE_EN
        checks++;
        if (glitch !== 1'b0) begin
            failures++;
            $display("FAIL reset glitch: got %b, required 0", glitch);
        end
`endif
    endtask

    task automatic test_model();
        mode = 0;
        model_code = 8'h6C;
        sweep("model_6c", 8'h6C, 8'h00, -1, -1);
        model_code = 8'hA5;
        sweep("model_a5", 8'hA5, 8'h6C, -1, -1);
    endtask

    task automatic test_tied();
        mode = 1;
        sweep("tied0", 8'h00, 8'hA5, -1, -1);
        mode = 2;
        sweep("tied1", 8'hFF, 8'h00, -1, -1);
    endtask

    task automatic test_start_ignored();
        mode = 0;
        model_code = 8'h6C;
        sweep("start_mid", 8'h6C, 8'hFF, 10, -1);
        sweep("start_in_done", 8'h6C, 8'h6C, N + 1, -1);
    endtask

    task automatic test_back_to_back();
        int dones;
        int first_at;
        int second_at;
        mode = 0;
        model_code = 8'h3A;
        dones = 0;
        first_at = -1;
        second_at = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 2 * (N + 1) + 2; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_at < 0) first_at = c;
                else second_at = c;
            end
        end
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        checks++;
        if (dones < 2 || first_at != N + 1 || second_at != 2 * (N + 1) + 1) begin
            failures++;
            $display("FAIL back_to_back: dones=%0d at %0d,%0d, required %0d,%0d",
                     dones, first_at, second_at, N + 1, 2 * (N + 1) + 1);
        end
        checks++;
        if (code !== 8'h3A || busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back end: code=%h busy=%b, required 3a 0",
                     code, busy);
        end
    endtask

    task automatic test_reset_mid();
        int late_done;
        mode = 0;
        model_code = 8'h6C;
        late_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = (c != 15);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stim !== 3'd0 || code !== 8'h00 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b stim=%h code=%h done=%b, required 0 0 00 0",
                     busy, stim, code, done);
        end
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) late_done++;
        end
        checks++;
        if (late_done != 0) begin
            failures++;
            $display("FAIL reset_mid idle: %0d active cycles, required 0", late_done);
        end
        sweep("after_reset", 8'h6C, 8'h00, -1, -1);
    endtask

    task automatic test_settle0();
        int busy_err;
        int stim_err;
        int done_at;
        busy_err = 0;
        stim_err = 0;
        done_at  = -1;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 1; c <= N0 + 3; c++) begin
            @(posedge clk);
            #1 start0 = 1'b0;
            @(negedge clk);
            if (busy0 !== (c <= N0)) busy_err++;
            if (c <= N0 && stim0 !== 3'((c - 1) / HOLD0)) stim_err++;
            if (done0 === 1'b1 && done_at < 0) done_at = c;
        end
        checks++;
        if (done_at != N0 + 1) begin
            failures++;
            $display("FAIL settle0 done: at %0d, required %0d", done_at, N0 + 1);
        end
        checks++;
        if (busy_err != 0 || stim_err != 0) begin
            failures++;
            $display("FAIL settle0 timing: busy_err=%0d stim_err=%0d, required 0 0",
                     busy_err, stim_err);
        end
        checks++;
        if (code0 !== 8'h69) begin
            failures++;
            $display("FAIL settle0 code: got %h, required 69", code0);
        end
    endtask

`ifdef TT_VOTE_EN
    task automatic test_vote();
        mode = 0;
        model_code = 8'h6C;
        sweep("vote_glitch", 8'h6C, 8'h6C, -1, 3 * HOLD + HOLD - 1);
        checks++;
        if (glitch !== 1'b1) begin
            failures++;
            $display("FAIL vote glitch flag: got %b, required 1", glitch);
        end
        sweep("vote_clean", 8'h6C, 8'h6C, -1, -1);
        checks++;
        if (glitch !== 1'b0) begin
            failures++;
            $display("FAIL vote clean flag: got %b, required 0", glitch);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        failures   = 0;
        mode       = 0;
        model_code = 8'h6C;
        flip       = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start0     = 1'b0;
        test_reset();
        test_model();
        test_tied();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_settle0();
`ifdef TT_VOTE_EN
        test_vote();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
